// File: rtl/led_anim_seq.sv
// Frame sequencer for 7-segment LED animations: a prescaler paces a 5-bit frame index.
// Define LED_ANIM_PINGPONG_EN to play each pass up 0..31 and then back down to 0.
module led_anim_seq #(
  parameter int unsigned TICK_DIV = 25000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       stop,
  input  logic       pause,
  input  logic       loop_en,
  input  logic [1:0] speed,
  output logic [4:0] frame,
  output logic       frame_tick,
  output logic       busy,
  output logic       done
);

  localparam int unsigned CntW = 26;

  typedef enum logic {StIdle, StRun} state_e;

  state_e            r_state;
  logic [CntW-1:0]   r_presc;
  logic [4:0]        r_frame;
  logic              r_tick;
  logic              r_done;
`ifdef LED_ANIM_PINGPONG_EN
  logic              r_dir_down;
`endif

  logic [CntW-1:0]   w_period;
  logic [CntW-1:0]   w_limit;
  logic              w_step;

  // Fast speeds on tiny dividers can shift the period to zero; step every cycle then.
  always_comb begin
    w_period = CntW'(TICK_DIV >> speed);
    if (w_period == '0) w_period = CntW'(1);
    w_limit = w_period - CntW'(1);
    // >= so a speed change that lands below the current count steps right away
    w_step  = (r_presc >= w_limit);
  end

  always_ff @(posedge clk) begin
    r_tick <= 1'b0;
    r_done <= 1'b0;
    if (rst) begin
      r_state <= StIdle;
      r_presc <= '0;
      r_frame <= '0;
`ifdef LED_ANIM_PINGPONG_EN
      r_dir_down <= 1'b0;
`endif
    end else begin
      case (r_state)
        StIdle: begin
          if (start && !stop) begin
            r_state <= StRun;
            r_presc <= '0;
            r_frame <= '0;
`ifdef LED_ANIM_PINGPONG_EN
            r_dir_down <= 1'b0;
`endif
          end
        end
        StRun: begin
          if (stop) begin
            r_state <= StIdle;
            r_presc <= '0;
          end else if (start) begin
            r_presc <= '0;
            r_frame <= '0;
`ifdef LED_ANIM_PINGPONG_EN
            r_dir_down <= 1'b0;
`endif
          end else if (!pause) begin
            if (!w_step) begin
              r_presc <= r_presc + CntW'(1);
            end else begin
              r_presc <= '0;
`ifdef LED_ANIM_PINGPONG_EN
              r_tick <= 1'b1;
              if (!r_dir_down) begin
                if (r_frame == 5'd31) begin
                  r_dir_down <= 1'b1;
                  r_frame    <= 5'd30;
                end else begin
                  r_frame <= r_frame + 5'd1;
                end
              end else begin
                r_frame <= r_frame - 5'd1;
                if (r_frame == 5'd1) begin
                  r_dir_down <= 1'b0;
                  if (!loop_en) begin
                    r_state <= StIdle;
                    r_done  <= 1'b1;
                  end
                end
              end
`else
              if (r_frame == 5'd31) begin
                if (loop_en) begin
                  r_frame <= '0;
                  r_tick  <= 1'b1;
                end else begin
                  r_state <= StIdle;
                  r_done  <= 1'b1;
                end
              end else begin
                r_frame <= r_frame + 5'd1;
                r_tick  <= 1'b1;
              end
`endif
            end
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign frame      = r_frame;
  assign frame_tick = r_tick;
  assign done       = r_done;
  assign busy       = (r_state == StRun);

endmodule

// File: tb/tb_led_anim_seq.sv
// Scoreboard bench for led_anim_seq at TICK_DIV=4; expected {busy,done,frame_tick,frame}
// words are queued with each cycle's stimulus and compared after the clock edge.
module tb_led_anim_seq;

  localparam int unsigned TickDiv = 4;
`ifdef LED_ANIM_PINGPONG_EN
  localparam bit PingPong = 1'b1;
`else
  localparam bit PingPong = 1'b0;
`endif
  localparam int EndK      = PingPong ? 248 : 128;
  localparam int EndFrame  = PingPong ? 0 : 31;
  localparam int ExpTicks  = PingPong ? 62 : 31;

  logic       clk = 1'b0;
  logic       rst, start, stop, pause, loop_en;
  logic [1:0] speed;
  logic [4:0] frame;
  logic       frame_tick, busy, done;

  int         n_checks = 0;
  int         n_errors = 0;
  int         n_ticks  = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  led_anim_seq #(.TICK_DIV(TickDiv)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .stop       (stop),
    .pause      (pause),
    .loop_en    (loop_en),
    .speed      (speed),
    .frame      (frame),
    .frame_tick (frame_tick),
    .busy       (busy),
    .done       (done)
  );

  always @(negedge clk) if (frame_tick === 1'b1) n_ticks++;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_errors++;
      $display("FAIL %s obs=%h exp=%h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [7:0] pack(input int f, input bit t, input bit b, input bit d);
    return {b, d, t, 5'(f)};
  endfunction

  // Frame after s steps in looping play.
  function automatic int loop_frame(input int s);
    int p;
    if (PingPong) begin
      p = s % 62;
      return (p <= 31) ? p : 62 - p;
    end
    return s % 32;
  endfunction

  // One-shot play at speed 0: k cycles after the start edge.
  function automatic logic [7:0] exp_oneshot(input int k);
    int s;
    s = k / 4;
    if (k < EndK) return pack((s > 31) ? 62 - s : s, (k % 4) == 0, 1'b1, 1'b0);
    if (k == EndK) return pack(EndFrame, PingPong, 1'b0, 1'b1);
    return pack(EndFrame, 1'b0, 1'b0, 1'b0);
  endfunction

  task automatic cycle(input string tag, input logic [7:0] expv);
    exp_q.push_back(expv);
    @(posedge clk);
    #1;
    check_eq(tag, {24'h0, busy, done, frame_tick, frame}, {24'h0, exp_q.pop_front()});
    rst   = 1'b0;
    start = 1'b0;
    stop  = 1'b0;
  endtask

  initial begin
    int t0;
    int keff;
    rst = 1'b1; start = 1'b0; stop = 1'b0; pause = 1'b0; loop_en = 1'b0; speed = 2'd0;

    rst = 1'b1;
    cycle("reset0", pack(0, 0, 0, 0));
    rst = 1'b1;
    cycle("reset1", pack(0, 0, 0, 0));
    cycle("idle", pack(0, 0, 0, 0));

    // One-shot play, speed 0
    t0 = n_ticks;
    start = 1'b1;
    cycle("s1 start", pack(0, 0, 1, 0));
    for (int k = 1; k <= EndK + 4; k++) cycle($sformatf("s1 k=%0d", k), exp_oneshot(k));
    check_eq("s1 tick count", n_ticks - t0, ExpTicks);

    // Looping play, speed 1, then stop
    loop_en = 1'b1; speed = 2'd1;
    start = 1'b1;
    cycle("s2 start", pack(0, 0, 1, 0));
    for (int k = 1; k <= 140; k++)
      cycle($sformatf("s2 k=%0d", k), pack(loop_frame(k / 2), (k % 2) == 0, 1'b1, 1'b0));
    stop = 1'b1;
    cycle("s2 stop", pack(loop_frame(70), 0, 0, 0));
    cycle("s2 idle", pack(loop_frame(70), 0, 0, 0));

    // Pause for 10 cycles at frame 5 with prescaler at 1, then resume
    loop_en = 1'b0; speed = 2'd0;
    start = 1'b1;
    cycle("s3 start", pack(0, 0, 1, 0));
    for (int k = 1; k <= 46; k++) begin
      pause = (k >= 22 && k <= 31);
      keff  = (k < 22) ? k : (k <= 31) ? 21 : k - 10;
      cycle($sformatf("s3 k=%0d", k), pack(keff / 4, !pause && (keff % 4) == 0, 1'b1, 1'b0));
    end
    pause = 1'b0;

    // Start and stop together at frame 9: stop wins
    start = 1'b1; stop = 1'b1;
    cycle("s4 start+stop", pack(9, 0, 0, 0));
    for (int k = 0; k < 3; k++) begin
      stop = 1'b1; pause = 1'b1;
      cycle($sformatf("s4 idle k=%0d", k), pack(9, 0, 0, 0));
    end
    pause = 1'b0;
    start = 1'b1;
    cycle("s4 restart", pack(0, 0, 1, 0));
    for (int k = 1; k <= 8; k++) cycle($sformatf("s4 k=%0d", k), exp_oneshot(k));

    // Start while running restarts from frame 0
    start = 1'b1;
    cycle("s5 restart", pack(0, 0, 1, 0));
    for (int k = 1; k <= 68; k++) cycle($sformatf("s5 k=%0d", k), exp_oneshot(k));
    rst = 1'b1;
    cycle("s5 rst", pack(0, 0, 0, 0));
    cycle("s5 idle0", pack(0, 0, 0, 0));
    cycle("s5 idle1", pack(0, 0, 0, 0));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/led_anim_seq.md
LED_ANIM_SEQ -- requirements
Module: led_anim_seq

Interface
REQ-001 SHALL have parameter TICK_DIV, default 25000000; base clock cycles per frame step, legal range 4..2^26-1.
REQ-002 SHALL have port clk, input, 1 bit; sole clock, rising edge.
REQ-003 SHALL have port rst, input, 1 bit; synchronous, active-high reset.
REQ-004 SHALL have port start, input, 1 bit; one-cycle request to play a sequence from frame 0.
REQ-005 SHALL have port stop, input, 1 bit; one-cycle request to abort play.
REQ-006 SHALL have port pause, input, 1 bit; level, freezes stepping while high.
REQ-007 SHALL have port loop_en, input, 1 bit; level, selects continuous replay.
REQ-008 SHALL have port speed, input, 2 bits; step period = TICK_DIV >> speed cycles.
REQ-009 SHALL have port frame, output, 5 bits; current frame index for the 7-segment pattern decoders.
REQ-010 SHALL have port frame_tick, output, 1 bit; one-cycle pulse coincident with each frame change.
REQ-011 SHALL have port busy, output, 1 bit; high in RUN.
REQ-012 SHALL have port done, output, 1 bit; one-cycle pulse at natural end of sequence.

Function
REQ-013 SHALL implement states IDLE and RUN; all outputs registered.
REQ-014 SHALL, in IDLE, hold frame and the prescaler cleared, busy=0; start -> RUN with frame=0 and prescaler=0 on the next cycle.
REQ-015 SHALL, in RUN with pause=0, increment a prescaler each cycle; when it equals (TICK_DIV>>speed)-1 it clears and frame advances one step, frame_tick=1 for that cycle.
REQ-016 SHALL sample speed every cycle; a speed change takes effect on the current count, and if the count already exceeds the new limit the step occurs on the next cycle.
REQ-017 SHALL, in RUN with pause=1, hold prescaler and frame; frame_tick=0.
REQ-018 SHALL, on a step from frame 31 with loop_en=1, wrap frame to 0, stay in RUN, done=0.
REQ-019 SHALL, on a step from frame 31 with loop_en=0, keep frame at 31, go to IDLE, pulse done=1 and frame_tick=0 that cycle.
REQ-020 SHALL, on stop in RUN, go to IDLE next cycle, freeze frame at its current value, no done pulse.
REQ-021 SHALL give stop priority over start when both are high in the same cycle; state ends IDLE.
REQ-022 SHALL, on start in RUN (stop low), restart: frame=0, prescaler=0, remain RUN, no done pulse.
REQ-023 SHALL give stop priority over a simultaneous terminal step; done not pulsed.
REQ-024 SHALL ignore stop and pause in IDLE.

Reset
REQ-025 SHALL, while rst=1, force state IDLE, frame=0, prescaler=0, direction up, busy=0, frame_tick=0, done=0; rst overrides all inputs including mid-sequence.

Configuration
REQ-026 SHALL, with macro LED_ANIM_PINGPONG_EN defined, count frames up 0..31 then down 31..0 per pass (direction flips at 31 and at 0, 62 steps per pass); a pass ends on reaching 0 going down: loop_en=1 -> continue up, loop_en=0 -> IDLE with done pulse and frame=0; start/reset set direction up.
REQ-027 SHALL, without LED_ANIM_PINGPONG_EN, count up only per REQ-018/REQ-019 and contain no direction register.

Verification (TICK_DIV=4)
REQ-028 SHALL cover: reset, start at speed=0, loop_en=0 -> frame steps every 4 cycles 0..31, 31 frame_tick pulses, done pulse 4 cycles after frame=31, busy low, frame holds 31.
REQ-029 SHALL cover: loop_en=1, speed=1 -> frame steps every 2 cycles, 31->0 wrap, no done, busy stays 1.
REQ-030 SHALL cover: pause high 10 cycles at frame 5 -> frame stays 5, no ticks; resumes with remaining prescaler count.
REQ-031 SHALL cover: start and stop same cycle in RUN at frame 9 -> IDLE, frame=9, no done; then start alone -> frame=0, RUN.
REQ-032 SHALL cover: rst pulse mid-run at frame 17 -> next cycle frame=0, busy=0, done=0.
REQ-033 SHALL cover, with LED_ANIM_PINGPONG_EN: loop_en=0 -> frames 0..31..0, done after reaching 0, 62 frame_tick pulses.
